// File: rtl/decoder_frame_arbiter.sv
// Shares one decoder syndrome stream among NUM_REQ sources, one whole frame at a time,
// and routes each result frame back to its submitter through an in-order tag queue.
//   state  | meaning
//   S_IDLE | no grant held; pick the next requester round-robin if a tag is free
//   S_FWD  | pass the granted requester's words through until its terminator
module decoder_frame_arbiter #(
    parameter int          NUM_REQ    = 2,
    parameter int          TAG_DEPTH  = 4,
    parameter logic [31:0] TERMINATOR = 32'hffffffff
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [32*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [31:0]                 dec_in_data,
    output logic                        dec_in_valid,
    input  logic                        dec_in_ready,
    input  logic [31:0]                 dec_out_data,
    input  logic                        dec_out_valid,
    output logic                        dec_out_ready,
    output logic [31:0]                 rsp_data,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [$clog2(TAG_DEPTH):0]  in_flight,
    output logic [15:0]                 last_cycles,
    output logic [7:0]                  last_iters
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(TAG_DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW+1)'(TAG_DEPTH);

    typedef enum logic {S_IDLE, S_FWD} in_state_t;

    in_state_t       state, state_nxt;
    logic [GW-1:0]   grant, grant_nxt;
    logic [GW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [GW-1:0]   head;
    logic            q_empty;
    logic            push, pop, out_first, out_hs;
    int              best_d, d;

    // Round-robin: smallest distance past rr_ptr wins.
    always_comb begin
        pick   = rr_ptr;
        best_d = NUM_REQ;
        d      = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_valid[j]) begin
                d = (j + 2*NUM_REQ - int'(rr_ptr) - 1) % NUM_REQ;
                if (d < best_d) begin
                    best_d = d;
                    pick   = GW'(j);
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        rr_ptr_nxt   = rr_ptr;
        push         = 1'b0;
        req_ready    = '0;
        dec_in_data  = '0;
        dec_in_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if ((count < DEPTH_L) && (|req_valid)) begin
                    push      = 1'b1;
                    grant_nxt = pick;
                    state_nxt = S_FWD;
                end
            end
            S_FWD: begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (grant == GW'(j)) begin
                        dec_in_data  = req_data[32*j +: 32];
                        dec_in_valid = req_valid[j];
                        req_ready[j] = dec_in_ready;
                    end
                end
                if (dec_in_valid && dec_in_ready && (dec_in_data == TERMINATOR)) begin
                    rr_ptr_nxt = grant;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            grant  <= '0;
            rr_ptr <= GW'(NUM_REQ - 1);
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    assign q_empty = (count == '0);
    assign head    = tag_mem[rd_ptr];

    always_comb begin
        rsp_valid     = '0;
        dec_out_ready = 1'b0;
        rsp_data      = '0;
        if (!q_empty) begin
            rsp_data = dec_out_data;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (head == GW'(j)) begin
                    rsp_valid[j]  = dec_out_valid;
                    dec_out_ready = rsp_ready[j];
                end
            end
        end
    end

    assign out_hs    = dec_out_valid && dec_out_ready;
    assign pop       = out_hs && (dec_out_data == TERMINATOR);
    assign in_flight = count;

    // Tag storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= pick;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_first   <= 1'b1;
            last_cycles <= '0;
            last_iters  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (out_hs && out_first) begin
                last_cycles <= dec_out_data[15:0];
                last_iters  <= dec_out_data[23:16];
                out_first   <= 1'b0;
            end
            if (pop) out_first <= 1'b1;
        end
    end

endmodule
